// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: triangular sweep sequencer.
// Latches lo/hi/dwell/sweep-count on an accepted start. It then runs a counter
// lo->hi->lo for the requested number of sweeps, holding dwell extra cycles at
// each endpoint. It reports done, abort (by returning idle) and rejected starts.
module updown_sweep_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned SWEEP_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               updown,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweeps_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_DWELL_HI = 3'd2,
    S_DOWN     = 3'd3,
    S_DWELL_LO = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [SWEEP_W-1:0] n_q;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [WIDTH-1:0]   lo_nxt;
  logic [WIDTH-1:0]   hi_nxt;
  logic [DWELL_W-1:0] dwell_nxt;
  logic [SWEEP_W-1:0] n_nxt;
  logic [DWELL_W-1:0] dwell_cnt_nxt;
  logic [WIDTH-1:0]   count_nxt;
  logic [SWEEP_W-1:0] sweeps_done_nxt;
  logic               done_nxt;
  logic               err_nxt;

  logic               cfg_bad;
  logic               start_req;
  logic               abort;
  logic               at_hi;
  logic               at_lo;
  logic               dwell_zero;
  logic               dwell_cnt_zero;
  logic               last_sweep;
  logic [SWEEP_W-1:0] sweeps_inc;

  // Shared decode used by both the next-state and the datapath logic.
  assign cfg_bad        = (lo >= hi) || (n_sweeps == '0);
  assign start_req      = start && !stop;
  assign abort          = busy && stop;
  assign at_hi          = (count == hi_q);
  assign at_lo          = (count == lo_q);
  assign dwell_zero     = (dwell_q == '0);
  assign dwell_cnt_zero = (dwell_cnt == '0);
  assign sweeps_inc     = SWEEP_W'(sweeps_done + SWEEP_W'(1));
  assign last_sweep     = (sweeps_inc == n_q);

  // Direction and activity are decoded straight from the state register.
  assign busy   = (state == S_UP) || (state == S_DWELL_HI) ||
                  (state == S_DOWN) || (state == S_DWELL_LO);
  assign updown = (state == S_UP) || (state == S_DWELL_HI);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop overrides every busy transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req && !cfg_bad) state_nxt = S_UP;
        end
        S_UP: begin
          if (at_hi) state_nxt = dwell_zero ? S_DOWN : S_DWELL_HI;
        end
        S_DWELL_HI: begin
          if (dwell_cnt_zero) state_nxt = S_DOWN;
        end
        S_DOWN: begin
          if (at_lo) begin
            if (last_sweep)      state_nxt = S_DONE;
            else if (dwell_zero) state_nxt = S_UP;
            else                 state_nxt = S_DWELL_LO;
          end
        end
        S_DWELL_LO: begin
          if (dwell_cnt_zero) state_nxt = S_UP;
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Datapath next values: count, dwell timer, sweep tally, config latch, pulses.
  always_comb begin
    count_nxt       = count;
    sweeps_done_nxt = sweeps_done;
    dwell_cnt_nxt   = dwell_cnt;
    lo_nxt          = lo_q;
    hi_nxt          = hi_q;
    dwell_nxt       = dwell_q;
    n_nxt           = n_q;
    done_nxt        = 1'b0;
    err_nxt         = 1'b0;
    if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            if (cfg_bad) begin
              err_nxt = 1'b1;
            end else begin
              lo_nxt          = lo;
              hi_nxt          = hi;
              dwell_nxt       = dwell;
              n_nxt           = n_sweeps;
              count_nxt       = lo;
              sweeps_done_nxt = '0;
            end
          end
        end
        S_UP: begin
          if (at_hi) begin
            if (dwell_zero) count_nxt = WIDTH'(hi_q - WIDTH'(1));
            else            dwell_cnt_nxt = DWELL_W'(dwell_q - DWELL_W'(1));
          end else begin
            count_nxt = WIDTH'(count + WIDTH'(1));
          end
        end
        S_DWELL_HI: begin
          if (dwell_cnt_zero) count_nxt = WIDTH'(count - WIDTH'(1));
          else                dwell_cnt_nxt = DWELL_W'(dwell_cnt - DWELL_W'(1));
        end
        S_DOWN: begin
          if (at_lo) begin
            sweeps_done_nxt = sweeps_inc;
            if (last_sweep)      done_nxt = 1'b1;
            else if (dwell_zero) count_nxt = WIDTH'(lo_q + WIDTH'(1));
            else                 dwell_cnt_nxt = DWELL_W'(dwell_q - DWELL_W'(1));
          end else begin
            count_nxt = WIDTH'(count - WIDTH'(1));
          end
        end
        S_DWELL_LO: begin
          if (dwell_cnt_zero) count_nxt = WIDTH'(count + WIDTH'(1));
          else                dwell_cnt_nxt = DWELL_W'(dwell_cnt - DWELL_W'(1));
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      sweeps_done <= '0;
      dwell_cnt   <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      dwell_q     <= '0;
      n_q         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      count       <= count_nxt;
      sweeps_done <= sweeps_done_nxt;
      dwell_cnt   <= dwell_cnt_nxt;
      lo_q        <= lo_nxt;
      hi_q        <= hi_nxt;
      dwell_q     <= dwell_nxt;
      n_q         <= n_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with hand-computed expectations.
module tb_updown_sweep_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] dwell;
  logic [7:0] n_sweeps;
  logic [3:0] count;
  logic       updown;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sweeps_done;

  int pass_cnt;
  int total_cnt;
  int done_seen;

  updown_sweep_ctrl #(.WIDTH(4), .DWELL_W(4), .SWEEP_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .lo          (lo),
    .hi          (hi),
    .dwell       (dwell),
    .n_sweeps    (n_sweeps),
    .count       (count),
    .updown      (updown),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sweeps_done (sweeps_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".updown"}, 32'(updown), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".sweeps"}, 32'(sweeps_done), 0);
  endtask

  int exp_basic_cnt[13] = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
  int exp_basic_up [13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
  int exp_dwell_cnt[9]  = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
  int exp_dwell_up [9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int exp_ign_cnt  [8]  = '{2, 3, 4, 5, 5, 4, 3, 2};

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    lo = 4'd0;
    hi = 4'd0;
    dwell = 4'd0;
    n_sweeps = 8'd0;
    pass_cnt = 0;
    total_cnt = 0;
    done_seen = 0;

    // Reset values
    tick();
    tick();
    chk_idle_zero("reset");
    reset = 1'b0;
    tick();
    chk("post_reset.busy", 32'(busy), 0);

    // Basic: lo=2 hi=5 dwell=0 n=2
    lo = 4'd2; hi = 4'd5; dwell = 4'd0; n_sweeps = 8'd2; start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("basic.count[%0d]", i), 32'(count), 32'(exp_basic_cnt[i]));
      chk($sformatf("basic.updown[%0d]", i), 32'(updown), 32'(exp_basic_up[i]));
      chk($sformatf("basic.busy[%0d]", i), 32'(busy), 1);
      chk($sformatf("basic.done[%0d]", i), 32'(done), 0);
    end
    tick();
    chk("basic.done_cycle.done", 32'(done), 1);
    chk("basic.done_cycle.busy", 32'(busy), 0);
    chk("basic.done_cycle.count", 32'(count), 2);
    chk("basic.done_cycle.sweeps", 32'(sweeps_done), 2);
    chk("basic.done_cycle.err", 32'(err), 0);
    tick();
    chk("basic.after.done", 32'(done), 0);
    chk("basic.after.busy", 32'(busy), 0);

    // Dwell: lo=0 hi=3 dwell=2 n=1
    lo = 4'd0; hi = 4'd3; dwell = 4'd2; n_sweeps = 8'd1; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("dwell.count[%0d]", i), 32'(count), 32'(exp_dwell_cnt[i]));
      chk($sformatf("dwell.updown[%0d]", i), 32'(updown), 32'(exp_dwell_up[i]));
      chk($sformatf("dwell.busy[%0d]", i), 32'(busy), 1);
    end
    tick();
    chk("dwell.done", 32'(done), 1);
    chk("dwell.sweeps", 32'(sweeps_done), 1);
    chk("dwell.busy_done", 32'(busy), 0);
    tick();
    chk("dwell.done_clear", 32'(done), 0);

    // Error: lo == hi
    lo = 4'd5; hi = 4'd5; dwell = 4'd0; n_sweeps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_eq.err", 32'(err), 1);
    chk("err_eq.busy", 32'(busy), 0);
    chk("err_eq.count", 32'(count), 0);
    chk("err_eq.sweeps", 32'(sweeps_done), 1);
    chk("err_eq.done", 32'(done), 0);
    tick();
    chk("err_eq.clear", 32'(err), 0);

    // Error: n_sweeps == 0
    lo = 4'd1; hi = 4'd4; n_sweeps = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_n0.err", 32'(err), 1);
    chk("err_n0.busy", 32'(busy), 0);
    chk("err_n0.count", 32'(count), 0);
    tick();
    chk("err_n0.clear", 32'(err), 0);

    // Start with stop in IDLE: nothing happens, even with a bad config
    lo = 4'd5; hi = 4'd5; n_sweeps = 8'd1; start = 1'b1; stop = 1'b1;
    tick();
    chk("stop_idle_bad.err", 32'(err), 0);
    lo = 4'd1; hi = 4'd4;
    tick();
    chk("stop_idle.err", 32'(err), 0);
    chk("stop_idle.busy", 32'(busy), 0);
    chk("stop_idle.count", 32'(count), 0);
    start = 1'b0; stop = 1'b0;

    // Abort while rising at count 4 (lo=2 hi=7)
    lo = 4'd2; hi = 4'd7; dwell = 4'd0; n_sweeps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort.start_count", 32'(count), 2);
    chk("abort.start_sweeps", 32'(sweeps_done), 0);
    tick();
    tick();
    chk("abort.pre_count", 32'(count), 4);
    chk("abort.pre_updown", 32'(updown), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.count", 32'(count), 4);
    chk("abort.done", 32'(done), 0);
    tick();
    chk("abort.hold_count", 32'(count), 4);
    chk("abort.hold_busy", 32'(busy), 0);
    chk("abort.hold_done", 32'(done), 0);

    // Restart then reset mid-sweep (lo=1 hi=9)
    lo = 4'd1; hi = 4'd9; dwell = 4'd0; n_sweeps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.count", 32'(count), 1);
    chk("restart.busy", 32'(busy), 1);
    chk("restart.sweeps", 32'(sweeps_done), 0);
    tick();
    tick();
    chk("midsweep.count", 32'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_zero("async_reset");
    tick();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_async.busy[%0d]", i), 32'(busy), 0);
    end
    chk("post_async.count", 32'(count), 0);

    // Ignore start/config changes mid-sweep: lo=2 hi=5 dwell=1 n=1
    lo = 4'd2; hi = 4'd5; dwell = 4'd1; n_sweeps = 8'd1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = (i == 2);
      if (i == 2) begin
        hi = 4'd9;
        lo = 4'd0;
      end
      chk($sformatf("ignore.count[%0d]", i), 32'(count), 32'(exp_ign_cnt[i]));
      chk($sformatf("ignore.busy[%0d]", i), 32'(busy), 1);
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_seen++;
      if (i == 0) begin
        chk("ignore.done_count", 32'(count), 2);
        chk("ignore.done_sweeps", 32'(sweeps_done), 1);
      end
    end
    chk("ignore.done_pulses", 32'(done_seen), 1);
    chk("ignore.final_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
